// File: rtl/bus_grant_dispatcher.sv
// Pops requester IDs from a request queue and grants the shared bus to one
// owner at a time, with a hold timeout and a single dead cycle after each grant.
module bus_grant_dispatcher #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] buf_out,
  input  logic       buf_empty,
  output logic       rd_en,
  input  logic [7:0] Com_Bus_Req,
  output logic [7:0] Com_Bus_Gnt,
  output logic [3:0] gnt_id,
  output logic       bus_busy,
  output logic       err_bad_id,
  output logic       stale_drop,
  output logic       timeout
);

  localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

  typedef enum logic [2:0] {S_IDLE, S_POP, S_LOAD, S_GRANT, S_RELEASE} state_t;

  state_t     state_q, state_d;
  logic       armed_q, armed_d;
  logic [3:0] id_q, id_d;
  logic [7:0] cnt_q, cnt_d;
  logic       rd_en_q, rd_en_d;
  logic [7:0] gnt_q, gnt_d;
  logic [3:0] gnt_id_q, gnt_id_d;
  logic       busy_q, busy_d;
  logic       err_q, err_d;
  logic       stale_q, stale_d;
  logic       to_q, to_d;

  logic [2:0] ld_idx, own_idx;
  logic       ld_bad;

  assign ld_idx  = buf_out[2:0] - 3'd1;
  assign own_idx = id_q[2:0] - 3'd1;
  assign ld_bad  = (buf_out == 4'd0) || (buf_out > 4'd8);

  always_comb begin
    state_d  = state_q;
    armed_d  = 1'b1;
    id_d     = id_q;
    cnt_d    = 8'd0;
    rd_en_d  = 1'b0;
    gnt_d    = 8'd0;
    gnt_id_d = 4'd0;
    busy_d   = 1'b0;
    err_d    = 1'b0;
    stale_d  = 1'b0;
    to_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        // armed_q keeps the first post-reset edge from popping
        if (!buf_empty && armed_q) begin
          state_d = S_POP;
          rd_en_d = 1'b1;
        end
      end
      S_POP: state_d = S_LOAD;
      S_LOAD: begin
        if (ld_bad) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else if (!Com_Bus_Req[ld_idx]) begin
          state_d = S_IDLE;
          stale_d = 1'b1;
        end else begin
          state_d        = S_GRANT;
          id_d           = buf_out;
          cnt_d          = 8'd1;
          gnt_d[ld_idx]  = 1'b1;
          gnt_id_d       = buf_out;
          busy_d         = 1'b1;
        end
      end
      S_GRANT: begin
        // a request drop wins over a coincident timeout
        if (!Com_Bus_Req[own_idx]) begin
          state_d = S_RELEASE;
        end else if (cnt_q == TO_LIM) begin
          state_d = S_RELEASE;
          to_d    = 1'b1;
        end else begin
          cnt_d    = cnt_q + 8'd1;
          gnt_d    = gnt_q;
          gnt_id_d = id_q;
          busy_d   = 1'b1;
        end
      end
      S_RELEASE: begin
        state_d = S_IDLE;
        id_d    = 4'd0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      armed_q  <= 1'b0;
      id_q     <= 4'd0;
      cnt_q    <= 8'd0;
      rd_en_q  <= 1'b0;
      gnt_q    <= 8'd0;
      gnt_id_q <= 4'd0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      stale_q  <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      armed_q  <= armed_d;
      id_q     <= id_d;
      cnt_q    <= cnt_d;
      rd_en_q  <= rd_en_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
      stale_q  <= stale_d;
      to_q     <= to_d;
    end
  end

  assign rd_en       = rd_en_q;
  assign Com_Bus_Gnt = gnt_q;
  assign gnt_id      = gnt_id_q;
  assign bus_busy    = busy_q;
  assign err_bad_id  = err_q;
  assign stale_drop  = stale_q;
  assign timeout     = to_q;

endmodule

// File: tb/tb_bus_grant_dispatcher.sv
// Directed bench: a small sync-read queue model feeds the dispatcher (TIMEOUT=4).
module tb_bus_grant_dispatcher;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] buf_out = 4'd0;
  logic       buf_empty;
  logic       rd_en;
  logic [7:0] Com_Bus_Req = 8'd0;
  logic [7:0] Com_Bus_Gnt;
  logic [3:0] gnt_id;
  logic       bus_busy, err_bad_id, stale_drop, timeout;

  int n_chk = 0;
  int n_err = 0;

  logic [3:0] mem [0:15];
  int wp = 0;
  int rp = 0;

  always #5 clk = ~clk;

  bus_grant_dispatcher #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .buf_out(buf_out), .buf_empty(buf_empty), .rd_en(rd_en),
    .Com_Bus_Req(Com_Bus_Req), .Com_Bus_Gnt(Com_Bus_Gnt), .gnt_id(gnt_id),
    .bus_busy(bus_busy), .err_bad_id(err_bad_id), .stale_drop(stale_drop),
    .timeout(timeout)
  );

  // queue presents the popped entry one cycle after rd_en
  always @(posedge clk) begin
    if (rd_en) begin
      buf_out <= mem[rp[3:0]];
      rp <= rp + 1;
    end
  end
  assign buf_empty = (wp == rp);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic push(input logic [3:0] id);
    mem[wp[3:0]] = id;
    wp = wp + 1;
  endtask

  task automatic idle_outs(input string tag);
    chk({tag, "_gnt"}, 32'(Com_Bus_Gnt), 32'h0);
    chk({tag, "_id"}, 32'(gnt_id), 32'h0);
    chk({tag, "_busy"}, 32'(bus_busy), 32'h0);
  endtask

  always @(negedge clk) chk("onehot", 32'($countones(Com_Bus_Gnt) <= 1), 32'h1);

  initial begin
    // reset state, entry for ID 3 already waiting
    Com_Bus_Req = 8'h04;
    push(4'd3);
    tick; tick;
    idle_outs("rst");
    chk("rst_rden", 32'(rd_en), 32'h0);
    chk("rst_pulses", {29'd0, err_bad_id, stale_drop, timeout}, 32'h0);
    rst = 1'b0;

    // first edge after reset must not pop
    tick; chk("arm_rden0", 32'(rd_en), 32'h0);
    tick; chk("pop_rden1", 32'(rd_en), 32'h1);
    tick; chk("load_rden0", 32'(rd_en), 32'h0); idle_outs("load");
    tick; chk("g3_gnt", 32'(Com_Bus_Gnt), 32'h04);
    chk("g3_id", 32'(gnt_id), 32'h3); chk("g3_busy", 32'(bus_busy), 32'h1);
    tick; chk("g3_hold", 32'(Com_Bus_Gnt), 32'h04);
    Com_Bus_Req = 8'h00;
    tick; idle_outs("rel3"); chk("rel3_to", 32'(timeout), 32'h0);
    tick; idle_outs("idle3");

    // bad IDs 0 and 12
    push(4'd0); push(4'd12);
    tick; chk("bad0_rden", 32'(rd_en), 32'h1);
    tick;
    tick; chk("bad0_err", 32'(err_bad_id), 32'h1); idle_outs("bad0");
    tick; chk("bad12_err0", 32'(err_bad_id), 32'h0); chk("bad12_rden", 32'(rd_en), 32'h1);
    tick;
    tick; chk("bad12_err", 32'(err_bad_id), 32'h1); idle_outs("bad12");
    tick; chk("bad12_err_end", 32'(err_bad_id), 32'h0);

    // stale ID 5, next entry still popped
    push(4'd5); push(4'd3);
    tick; tick;
    tick; chk("stale5", 32'(stale_drop), 32'h1); idle_outs("stale5");
    tick; chk("stale5_end", 32'(stale_drop), 32'h0); chk("stale_next_pop", 32'(rd_en), 32'h1);
    tick;
    tick; chk("stale3", 32'(stale_drop), 32'h1);
    tick;

    // timeout: ID 1 held high, grant lasts exactly 4 cycles
    Com_Bus_Req = 8'h01; push(4'd1);
    tick; tick;
    for (int i = 0; i < 4; i++) begin
      tick; chk("to_gnt", 32'(Com_Bus_Gnt), 32'h01); chk("to_nopulse", 32'(timeout), 32'h0);
    end
    tick; chk("to_pulse", 32'(timeout), 32'h1); idle_outs("to_rel");
    tick; chk("to_pulse_end", 32'(timeout), 32'h0);

    // drop coincides with the last permitted cycle: plain release
    push(4'd1);
    tick; tick;
    for (int i = 0; i < 4; i++) begin
      tick; chk("tie_gnt", 32'(Com_Bus_Gnt), 32'h01);
    end
    Com_Bus_Req = 8'h00;
    tick; chk("tie_to", 32'(timeout), 32'h0); idle_outs("tie_rel");
    tick;

    // back-to-back IDs 2 and 7; toggling requester 1 is ignored
    Com_Bus_Req = 8'h42; push(4'd2); push(4'd7);
    tick; tick;
    for (int i = 0; i < 3; i++) begin
      tick; chk("b2b_g2", 32'(Com_Bus_Gnt), 32'h02); chk("b2b_id2", 32'(gnt_id), 32'h2);
      Com_Bus_Req[0] = ~Com_Bus_Req[0];
    end
    Com_Bus_Req = 8'h40;
    for (int i = 0; i < 4; i++) begin
      tick; idle_outs("b2b_gap");
    end
    for (int i = 0; i < 3; i++) begin
      tick; chk("b2b_g7", 32'(Com_Bus_Gnt), 32'h40); chk("b2b_id7", 32'(gnt_id), 32'h7);
    end
    Com_Bus_Req = 8'h00;
    tick; idle_outs("b2b_rel");
    tick;

    // reset during the second grant cycle; the entry is not re-popped
    Com_Bus_Req = 8'h08; push(4'd4);
    tick; tick;
    tick; chk("rg_gnt", 32'(Com_Bus_Gnt), 32'h08);
    @(posedge clk); #2 rst = 1'b1;
    #1 idle_outs("rg_async"); chk("rg_rden", 32'(rd_en), 32'h0);
    tick; rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick; chk("rg_norepop", 32'(rd_en), 32'h0); idle_outs("rg_after");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/bus_grant_dispatcher.md
BUS_GRANT_DISPATCHER -- requirements
Module: bus_grant_dispatcher

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset, with ports named clk and rst; all state SHALL change on posedge clk except on reset.
REQ-002 The block SHALL have parameter TIMEOUT, default 64, range 1..255: the maximum number of cycles a grant is held.
REQ-003 clk  input  1  system clock.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 buf_out  input  4  head entry of the request queue; values 1..8 name requesters 1..8 (bit i+1 -> Com_Bus_Req[i]).
REQ-006 buf_empty  input  1  request queue empty.
REQ-007 rd_en  output  1  pop strobe to the request queue.
REQ-008 Com_Bus_Req  input  8  live request level per requester.
REQ-009 Com_Bus_Gnt  output  8  one-hot bus grant.
REQ-010 gnt_id  output  4  current owner ID (1..8), 0 when no grant.
REQ-011 bus_busy  output  1  high while any grant bit is high.
REQ-012 err_bad_id  output  1  one-cycle pulse: popped ID was 0 or 9..15.
REQ-013 stale_drop  output  1  one-cycle pulse: popped ID's request was already low.
REQ-014 timeout  output  1  one-cycle pulse: grant revoked by TIMEOUT.

Function
REQ-015 The block SHALL implement FSM states IDLE, POP, LOAD, GRANT and RELEASE, with all outputs registered.
REQ-016 IDLE: buf_empty sampled low SHALL move to POP; otherwise the FSM SHALL stay in IDLE.
REQ-017 POP: rd_en SHALL be high for exactly this one cycle, then the FSM SHALL move to LOAD; rd_en SHALL be low in every other state.
REQ-018 LOAD: buf_out SHALL be sampled; ID 1..8 with Com_Bus_Req[ID-1]=1 SHALL go to GRANT.
REQ-019 LOAD: ID 0 or 9..15 SHALL pulse err_bad_id and return to IDLE with no grant.
REQ-020 LOAD: a valid ID whose request is low SHALL pulse stale_drop and return to IDLE.
REQ-021 GRANT: Com_Bus_Gnt[ID-1]=1 only, gnt_id=ID and bus_busy=1; latency SHALL be buf_empty low at cycle N -> rd_en at N+1 -> grant visible at N+3.
REQ-022 GRANT: an 8-bit hold counter SHALL start at 1 on the first GRANT cycle and increment every cycle.
REQ-023 GRANT: Com_Bus_Req[ID-1] sampled low SHALL move to RELEASE.
REQ-024 GRANT: counter equal to TIMEOUT with the request still high SHALL move to RELEASE with timeout pulsed in RELEASE.
REQ-025 When the request drop and counter==TIMEOUT occur in the same cycle, the block SHALL perform a normal release with no timeout pulse.
REQ-026 RELEASE: Com_Bus_Gnt=0, gnt_id=0 and bus_busy=0 for exactly one dead cycle, then the FSM SHALL go to IDLE.
REQ-027 Back-to-back grants SHALL therefore be separated by at least 4 non-grant cycles (RELEASE, IDLE, POP, LOAD).
REQ-028 Changes on requests other than the owner's SHALL be ignored during GRANT.
REQ-029 Com_Bus_Gnt SHALL never have more than one bit set.
REQ-030 rd_en SHALL never be asserted while buf_empty is sampled high in IDLE.

Reset
REQ-031 rst high SHALL immediately force state=IDLE, rd_en=0, Com_Bus_Gnt=0, gnt_id=0, bus_busy=0, err_bad_id=0, stale_drop=0, timeout=0 and hold counter=0.
REQ-032 Reset asserted mid-GRANT SHALL drop the grant asynchronously; the lost entry SHALL NOT be re-popped.
REQ-033 After rst falls, the first rd_en SHALL occur no earlier than the second posedge clk.

Verification
REQ-034 Queue holds ID 3 and Com_Bus_Req=8'b0000_0100 -> rd_en 1 cycle, then Com_Bus_Gnt=8'b0000_0100 and gnt_id=3 at N+3; dropping req[2] -> grant 0 the next cycle, then 1 dead cycle.
REQ-035 buf_out=0 and then buf_out=12 popped -> err_bad_id pulses twice, Com_Bus_Gnt stays 0.
REQ-036 ID 5 popped with Com_Bus_Req=0 -> stale_drop=1 for 1 cycle, no grant, next pop follows.
REQ-037 TIMEOUT=4, ID 1 held high -> Com_Bus_Gnt[0] high exactly 4 cycles, timeout=1 in RELEASE.
REQ-038 Queue holds IDs 2,7 with both requests high, each dropped after 3 grant cycles -> grants serialized, one-hot, with ≥4 idle cycles between grants.
REQ-039 rst pulsed during the 2nd grant cycle -> all outputs 0 within the same cycle and FSM in IDLE.
